// File: rtl/pll_ctrl.sv
// ---------------------------------------------------------------------------
// pll_ctrl -- PLL bring-up, lock supervision and output-divider reprogramming
//
// Sequences an external PLL: holds it in reset for a fixed number of cycles,
// waits (with timeout) for its lock indication, requires the lock to be
// stable for a number of consecutive cycles, then releases the downstream
// reset. Lock loss or a divider reconfiguration request restarts the
// sequence; too many failed attempts park the controller in FAIL until
// retry_clr is pulsed.
//
// Ports
//   clk         in   reference clock (the only clock of this block)
//   resetn      in   asynchronous active-low reset
//   pll_lock    in   PLL lock, asynchronous to clk (synchronized here)
//   cfg_req     in   divider reprogramming request, held until cfg_ack
//   cfg_odsel   in   requested divider, captured with cfg_ack
//   retry_clr   in   one-cycle pulse, leaves FAIL and restarts sequencing
//   pll_reset   out  active-high PLL reset
//   odsel       out  divider value driven to the PLL
//   cfg_ack     out  one-cycle acceptance pulse for cfg_req
//   sys_resetn  out  active-low downstream reset, high only in RUN
//   locked      out  high only in RUN
//   fail        out  high only in FAIL
//   retry_cnt   out  failed attempts since last lock, retry_clr or reset
// ---------------------------------------------------------------------------
module pll_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_STABLE  = 256,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         MAX_RETRY    = 3,
  parameter logic [6:0] ODSEL_INIT   = 7'd100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       cfg_req,
  input  logic [6:0] cfg_odsel,
  input  logic       retry_clr,
  output logic       pll_reset,
  output logic [6:0] odsel,
  output logic       cfg_ack,
  output logic       sys_resetn,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  // Each counter only ever holds 0 .. PARAM-1: the terminal condition is
  // detected on the last stored value, so $clog2(PARAM) bits suffice and
  // no counter can wrap.
  localparam int RW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
  localparam int SW = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);

  localparam logic [2:0] ST_RST_PLL   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  // Lock synchronizer
  logic lock_meta_q;
  logic lock_sync_q;

  // FSM state, counters and registered outputs
  logic [2:0]    state_q,      state_d;
  logic [RW-1:0] rst_cnt_q,    rst_cnt_d;
  logic [SW-1:0] stb_cnt_q,    stb_cnt_d;
  logic [TW-1:0] to_cnt_q,     to_cnt_d;
  logic [2:0]    retry_q,      retry_d;
  logic [6:0]    odsel_q,      odsel_d;
  logic          cfg_ack_q,    cfg_ack_d;
  logic          pll_reset_q,  pll_reset_d;
  logic          sys_resetn_q, sys_resetn_d;
  logic          locked_q,     locked_d;
  logic          fail_q,       fail_d;

  logic lock;
  logic go_rst;
  logic attempt_fail;

  assign lock = lock_sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    stb_cnt_d    = stb_cnt_q;
    to_cnt_d     = to_cnt_q;
    retry_d      = retry_q;
    odsel_d      = odsel_q;
    cfg_ack_d    = 1'b0;
    go_rst       = 1'b0;
    attempt_fail = 1'b0;

    case (state_q)
      ST_RST_PLL: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d  = ST_WAIT_LOCK;
          to_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (lock) begin
          // The first locked cycle already counts as one stable cycle.
          stb_cnt_d = SW'(1);
          if (LOCK_STABLE == 1) begin
            state_d = ST_RUN;
            retry_d = 3'd0;
          end else begin
            state_d = ST_STABLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      ST_STABLE: begin
        if (lock) begin
          if (stb_cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = 3'd0;
          end else begin
            stb_cnt_d = stb_cnt_q + SW'(1);
          end
        end else begin
          // A lock glitch only restarts the stability window; the timeout
          // counter keeps its value so a chattering lock still times out.
          state_d = ST_WAIT_LOCK;
        end
      end

      ST_RUN: begin
        // A reconfiguration request takes priority over a coincident lock
        // loss so the new divider is never dropped.
        if (cfg_req) begin
          cfg_ack_d = 1'b1;
          odsel_d   = cfg_odsel;
          go_rst    = 1'b1;
        end else if (!lock) begin
          go_rst = 1'b1;
        end
      end

      ST_FAIL: begin
        if (retry_clr) begin
          retry_d = 3'd0;
          go_rst  = 1'b1;
        end
      end

      default: begin
        go_rst = 1'b1;
      end
    endcase

    if (attempt_fail) begin
      retry_d = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;
      if (int'(retry_d) >= MAX_RETRY) begin
        state_d = ST_FAIL;
      end else begin
        go_rst = 1'b1;
      end
    end

    if (go_rst) begin
      state_d   = ST_RST_PLL;
      rst_cnt_d = '0;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state transition.
    pll_reset_d  = (state_d == ST_RST_PLL) || (state_d == ST_FAIL);
    sys_resetn_d = (state_d == ST_RUN);
    locked_d     = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RST_PLL;
      rst_cnt_q    <= '0;
      stb_cnt_q    <= '0;
      to_cnt_q     <= '0;
      retry_q      <= 3'd0;
      odsel_q      <= ODSEL_INIT;
      cfg_ack_q    <= 1'b0;
      pll_reset_q  <= 1'b1;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      to_cnt_q     <= to_cnt_d;
      retry_q      <= retry_d;
      odsel_q      <= odsel_d;
      cfg_ack_q    <= cfg_ack_d;
      pll_reset_q  <= pll_reset_d;
      sys_resetn_q <= sys_resetn_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_reset  = pll_reset_q;
  assign odsel      = odsel_q;
  assign cfg_ack    = cfg_ack_q;
  assign sys_resetn = sys_resetn_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_ctrl -- directed self-checking bench for pll_ctrl
//
// Power-up, reconfiguration, lock loss coinciding with cfg_req, cfg_req
// hold-off outside RUN, lock glitch in STABLE, asynchronous reset in the
// middle of STABLE, and the retry/timeout path into FAIL and out again.
// LOCK_TIMEOUT is shortened to 1000 to keep the run short; the other
// parameters are the defaults. Edge numbers in comments are relative to
// the named reference edge; all sampling is 1 time unit after an edge.
// ---------------------------------------------------------------------------
module tb_pll_ctrl;

  logic       clk;
  logic       resetn;
  logic       pll_lock;
  logic       cfg_req;
  logic [6:0] cfg_odsel;
  logic       retry_clr;
  logic       pll_reset;
  logic [6:0] odsel;
  logic       cfg_ack;
  logic       sys_resetn;
  logic       locked;
  logic       fail;
  logic [2:0] retry_cnt;

  int checks = 0;
  int errors = 0;
  int ack_seen;
  int rst_seen;

  pll_ctrl #(
    .RST_CYCLES  (16),
    .LOCK_STABLE (256),
    .LOCK_TIMEOUT(1000),
    .MAX_RETRY   (3),
    .ODSEL_INIT  (7'd100)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pll_lock  (pll_lock),
    .cfg_req   (cfg_req),
    .cfg_odsel (cfg_odsel),
    .retry_clr (retry_clr),
    .pll_reset (pll_reset),
    .odsel     (odsel),
    .cfg_ack   (cfg_ack),
    .sys_resetn(sys_resetn),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-24s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    resetn    = 1'b0;
    pll_lock  = 1'b0;
    cfg_req   = 1'b0;
    cfg_odsel = 7'd0;
    retry_clr = 1'b0;

    // ---------------- reset state ----------------
    step(3);
    chk("rst_pll_reset",  32'(pll_reset),  32'd1);
    chk("rst_odsel",      32'(odsel),      32'd100);
    chk("rst_cfg_ack",    32'(cfg_ack),    32'd0);
    chk("rst_sys_resetn", 32'(sys_resetn), 32'd0);
    chk("rst_locked",     32'(locked),     32'd0);
    chk("rst_fail",       32'(fail),       32'd0);
    chk("rst_retry",      32'(retry_cnt),  32'd0);

    // ---------------- power-up (P = release edge) ----------------
    resetn = 1'b1;
    step(15);                                   // P+15
    chk("pwr_pll_reset_hi", 32'(pll_reset), 32'd1);
    step(1);                                    // P+16
    chk("pwr_pll_reset_lo", 32'(pll_reset), 32'd0);
    step(84);                                   // P+100
    pll_lock = 1'b1;
    step(257);                                  // P+357
    chk("pwr_locked_early", 32'(locked),     32'd0);
    chk("pwr_sysrst_early", 32'(sys_resetn), 32'd0);
    step(1);                                    // P+358
    chk("pwr_locked",       32'(locked),     32'd1);
    chk("pwr_sys_resetn",   32'(sys_resetn), 32'd1);
    chk("pwr_retry",        32'(retry_cnt),  32'd0);

    // ---------------- reconfiguration (R = RUN edge) ----------------
    cfg_odsel = 7'd50;
    cfg_req   = 1'b1;
    step(1);                                    // R+1
    chk("cfg_ack_pulse",    32'(cfg_ack),    32'd1);
    chk("cfg_odsel_50",     32'(odsel),      32'd50);
    chk("cfg_sys_resetn",   32'(sys_resetn), 32'd0);
    chk("cfg_pll_reset",    32'(pll_reset),  32'd1);
    cfg_req = 1'b0;
    step(1);                                    // R+2
    chk("cfg_ack_one_cyc",  32'(cfg_ack),    32'd0);
    step(14);                                   // R+16
    chk("cfg_pll_reset_hi", 32'(pll_reset),  32'd1);
    step(1);                                    // R+17
    chk("cfg_pll_reset_lo", 32'(pll_reset),  32'd0);
    step(255);                                  // R+272
    chk("cfg_relock_early", 32'(locked),     32'd0);
    step(1);                                    // R+273
    chk("cfg_relock",       32'(locked),     32'd1);

    // ------- lock loss and cfg_req on the same edge (S = RUN edge) -------
    pll_lock = 1'b0;
    step(2);                                    // S+2: sync not yet low
    chk("both_still_run",   32'(locked),     32'd1);
    cfg_odsel = 7'd33;
    cfg_req   = 1'b1;
    step(1);                                    // S+3
    chk("both_cfg_ack",     32'(cfg_ack),    32'd1);
    chk("both_odsel_33",    32'(odsel),      32'd33);
    chk("both_pll_reset",   32'(pll_reset),  32'd1);
    chk("both_retry",       32'(retry_cnt),  32'd0);
    cfg_req  = 1'b0;
    pll_lock = 1'b1;
    step(1);                                    // S+4
    chk("both_ack_drop",    32'(cfg_ack),    32'd0);

    // ------- cfg_req held outside RUN is not acknowledged until RUN -------
    cfg_odsel = 7'd40;
    cfg_req   = 1'b1;
    ack_seen  = 0;
    rst_seen  = 0;
    for (int i = 0; i < 271; i++) begin         // S+5 .. S+275
      step(1);
      ack_seen += int'(cfg_ack);
      rst_seen += int'(pll_reset);
    end
    chk("hold_no_ack",      32'(ack_seen),   32'd0);
    chk("hold_single_rst",  32'(rst_seen),   32'd14);
    chk("hold_run",         32'(locked),     32'd1);
    step(1);                                    // S+276
    chk("hold_ack",         32'(cfg_ack),    32'd1);
    chk("hold_odsel_40",    32'(odsel),      32'd40);
    chk("hold_left_run",    32'(locked),     32'd0);
    cfg_req = 1'b0;

    // ------- lock glitch in STABLE (T = RST_PLL entry at S+276) -------
    step(216);                                  // T+216: stable count 200
    chk("gl_pre_locked",    32'(locked),     32'd0);
    chk("gl_pre_pll_reset", 32'(pll_reset),  32'd0);
    pll_lock = 1'b0;
    step(3);                                    // T+219
    pll_lock = 1'b1;
    chk("gl_no_rst",        32'(pll_reset),  32'd0);
    chk("gl_retry",         32'(retry_cnt),  32'd0);
    step(257);                                  // T+476
    chk("gl_restart_early", 32'(locked),     32'd0);
    step(1);                                    // T+477
    chk("gl_run",           32'(locked),     32'd1);
    chk("gl_run_retry",     32'(retry_cnt),  32'd0);

    // ------- lock loss in RUN, then async reset mid-STABLE (U = RUN) -------
    pll_lock = 1'b0;
    step(3);                                    // U+3
    chk("loss_pll_reset",   32'(pll_reset),  32'd1);
    chk("loss_locked",      32'(locked),     32'd0);
    chk("loss_retry",       32'(retry_cnt),  32'd0);
    pll_lock = 1'b1;
    step(116);                                  // U+119: stable count 100
    chk("mid_stable",       32'(pll_reset),  32'd0);
    resetn = 1'b0;
    #1;                                         // no clock edge in between
    chk("arst_pll_reset",   32'(pll_reset),  32'd1);
    chk("arst_odsel",       32'(odsel),      32'd100);
    chk("arst_sys_resetn",  32'(sys_resetn), 32'd0);
    chk("arst_locked",      32'(locked),     32'd0);
    chk("arst_fail",        32'(fail),       32'd0);
    chk("arst_cfg_ack",     32'(cfg_ack),    32'd0);
    step(3);
    resetn = 1'b1;                              // Q = release edge
    step(15);                                   // Q+15
    chk("re_pll_reset_hi",  32'(pll_reset),  32'd1);
    step(1);                                    // Q+16
    chk("re_pll_reset_lo",  32'(pll_reset),  32'd0);
    step(255);                                  // Q+271
    chk("re_locked_early",  32'(locked),     32'd0);
    step(1);                                    // Q+272
    chk("re_locked",        32'(locked),     32'd1);

    // ------- timeout path: three failed attempts, FAIL, retry_clr -------
    pll_lock = 1'b0;
    step(3);                                    // Q+275: lock loss
    chk("to_loss_rst",      32'(pll_reset),  32'd1);
    step(1015);                                 // Q+1290
    chk("to1_pre_retry",    32'(retry_cnt),  32'd0);
    chk("to1_pre_rst",      32'(pll_reset),  32'd0);
    step(1);                                    // Q+1291
    chk("to1_retry",        32'(retry_cnt),  32'd1);
    chk("to1_rst",          32'(pll_reset),  32'd1);
    step(109);                                  // Q+1400 (WAIT_LOCK)
    retry_clr = 1'b1;
    step(1);                                    // Q+1401
    retry_clr = 1'b0;
    chk("clr_ignored",      32'(retry_cnt),  32'd1);
    chk("clr_ignored_rst",  32'(pll_reset),  32'd0);
    step(905);                                  // Q+2306
    chk("to2_pre_retry",    32'(retry_cnt),  32'd1);
    step(1);                                    // Q+2307
    chk("to2_retry",        32'(retry_cnt),  32'd2);
    chk("to2_rst",          32'(pll_reset),  32'd1);
    step(1015);                                 // Q+3322
    chk("to3_pre_retry",    32'(retry_cnt),  32'd2);
    chk("to3_pre_fail",     32'(fail),       32'd0);
    step(1);                                    // Q+3323
    chk("to3_retry",        32'(retry_cnt),  32'd3);
    chk("to3_fail",         32'(fail),       32'd1);
    chk("to3_pll_reset",    32'(pll_reset),  32'd1);
    chk("to3_locked",       32'(locked),     32'd0);
    step(5);                                    // F
    chk("fail_hold",        32'(fail),       32'd1);
    chk("fail_hold_rst",    32'(pll_reset),  32'd1);
    retry_clr = 1'b1;
    step(1);                                    // F+1
    retry_clr = 1'b0;
    chk("clr_fail",         32'(fail),       32'd0);
    chk("clr_retry",        32'(retry_cnt),  32'd0);
    chk("clr_pll_reset",    32'(pll_reset),  32'd1);
    step(15);                                   // F+16
    chk("clr_rst_hi",       32'(pll_reset),  32'd1);
    step(1);                                    // F+17
    chk("clr_rst_lo",       32'(pll_reset),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_ctrl.md
PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: clk cycles pll_reset is held high per attempt (>=1).
REQ-002 SHALL have parameter LOCK_STABLE, default 256: consecutive synchronized-lock cycles required before lock is declared (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles allowed in WAIT_LOCK before the attempt fails (>=1).
REQ-004 SHALL have parameter MAX_RETRY, default 3: failed attempts tolerated before FAIL (1..7).
REQ-005 SHALL have parameter ODSEL_INIT, default 7'd100: odsel value after reset.
REQ-006 clk  input  1  reference clock (PLL input clock domain); one clock only.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 pll_lock  input  1  PLL lock, asynchronous to clk.
REQ-009 cfg_req  input  1  request to reprogram output divider; held until cfg_ack.
REQ-010 cfg_odsel  input  7  requested divider, sampled when cfg_ack is high.
REQ-011 retry_clr  input  1  one-cycle pulse; leaves FAIL and restarts sequencing.
REQ-012 pll_reset  output  1  active-high PLL reset.
REQ-013 odsel  output  7  divider value driven to PLL.
REQ-014 cfg_ack  output  1  one-cycle acceptance pulse for cfg_req.
REQ-015 sys_resetn  output  1  active-low reset for downstream logic, low unless state is RUN.
REQ-016 locked  output  1  high only in RUN.
REQ-017 fail  output  1  high only in FAIL.
REQ-018 retry_cnt  output  3  failed attempts since last successful lock, retry_clr or reset.

Function
REQ-019 pll_lock SHALL pass a 2-flop synchronizer; "lock" below means the synchronized value (2-cycle latency).
REQ-020 FSM states SHALL be RST_PLL, WAIT_LOCK, STABLE, RUN, FAIL.
REQ-021 RST_PLL: pll_reset=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK with cycle counter cleared.
REQ-022 WAIT_LOCK: pll_reset=0; lock=1 -> STABLE (stable counter=1); counter reaching LOCK_TIMEOUT without lock -> attempt failure.
REQ-023 STABLE: each lock=1 cycle increments stable counter; reaching LOCK_STABLE -> RUN and retry_cnt cleared; lock=0 -> back to WAIT_LOCK without clearing timeout counter (glitch is not a failure).
REQ-024 Attempt failure: retry_cnt increments (saturating at 7); if new retry_cnt >= MAX_RETRY -> FAIL, else -> RST_PLL.
REQ-025 RUN: lock=0 for any single cycle -> RST_PLL (lock loss); retry_cnt unchanged.
REQ-026 RUN with cfg_req=1: cfg_ack pulses one cycle, odsel loads cfg_odsel the same edge, -> RST_PLL; cfg_req outside RUN SHALL be held off (no ack) until RUN.
REQ-027 Simultaneous lock loss and cfg_req in RUN: cfg request SHALL win (ack issued, odsel updated, -> RST_PLL).
REQ-028 FAIL: pll_reset=1 held; retry_clr -> RST_PLL with retry_cnt cleared; retry_clr ignored in other states.
REQ-029 Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap.
REQ-030 sys_resetn and locked SHALL be registered outputs, deasserted/asserted on the same edge as entry to/exit from RUN.

Reset
REQ-031 On resetn=0 (any time, asynchronously): state=RST_PLL, pll_reset=1, odsel=ODSEL_INIT, cfg_ack=0, sys_resetn=0, locked=0, fail=0, retry_cnt=0, all counters and synchronizer flops 0.
REQ-032 After resetn release, RST_CYCLES counting SHALL start from the first clk edge.

Verification
REQ-033 Power-up: release resetn, pll_lock rises 100 cycles later and stays -> pll_reset high 16 cycles, locked/sys_resetn go high 256+2 cycles after pll_lock rise, retry_cnt=0.
REQ-034 Timeout: pll_lock held 0 -> three attempts of 16+65535 cycles, retry_cnt 1,2,3, then fail=1 and pll_reset=1; retry_clr pulse -> RST_PLL, retry_cnt=0.
REQ-035 Glitch: in STABLE drop pll_lock for 3 cycles at count 200 -> no retry increment, stable count restarts, RUN reached 256 cycles after lock returns.
REQ-036 Reconfig: in RUN, cfg_req=1 with cfg_odsel=7'd50 -> cfg_ack one cycle, odsel=50, sys_resetn=0 next cycle, pll_reset high 16 cycles, relock to RUN.
REQ-037 Lock loss + cfg_req same cycle in RUN -> cfg_ack=1, odsel updated, single RST_PLL entry, retry_cnt unchanged.
REQ-038 Reset mid-STABLE: assert resetn=0 at stable count 100 -> all outputs immediately at REQ-031 values, full sequence restarts after release.
